// File: rtl/beat_recorder.sv
// rtl/beat_recorder.sv - three-slot keyboard event recorder with timed playback
module beat_recorder #(
  parameter int TICK_DIV = 500000,
  parameter int DELTA_W  = 10,
  parameter int DEPTH    = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [6:0]               key_in,
  input  logic                     rec_btn,
  input  logic                     play_btn,
  input  logic [2:0]               slot_sel,
  output logic [6:0]               key_out,
  output logic                     recording,
  output logic                     playing,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   event_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MW = DELTA_W + 7;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REC   = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  localparam logic [DELTA_W-1:0] DMAX = '1;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [1:0]         state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [DELTA_W-1:0] delta_q, delta_d;
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [1:0]         slot_q, slot_d;
  logic [6:0]         prev_key_q, prev_key_d;
  logic [AW:0]        len_q [0:2];
  logic [AW:0]        len_d [0:2];
  logic [DELTA_W-1:0] wait_q, wait_d;
  logic [6:0]         held_q, held_d;
  logic [6:0]         key_q, key_d;
  logic               ph_q, ph_d;

  logic [MW-1:0]      mem [0:3*DEPTH-1];
  logic [MW-1:0]      rd_data_q;
  logic               we;
  logic [AW+1:0]      waddr, raddr;

  logic               tick;
  logic               sel_ok;
  logic [1:0]         sel_idx;
  logic [AW:0]        cur_len;

  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign cur_len = len_q[slot_q];
  assign waddr   = {slot_q, wr_ptr_q[AW-1:0]};
  assign raddr   = {slot_q, rd_ptr_q[AW-1:0]};

  // Decode the one-hot slot switches; anything else blocks a start
  always_comb begin
    sel_ok  = 1'b1;
    sel_idx = 2'd0;
    case (slot_sel)
      3'b001:  sel_idx = 2'd0;
      3'b010:  sel_idx = 2'd1;
      3'b100:  sel_idx = 2'd2;
      default: sel_ok  = 1'b0;
    endcase
  end

  // Next-state logic for the recorder/player and its timing counters
  always_comb begin
    state_d    = state_q;
    presc_d    = tick ? '0 : presc_q + 1'b1;
    delta_d    = (tick && delta_q != DMAX) ? delta_q + 1'b1 : delta_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    slot_d     = slot_q;
    prev_key_d = prev_key_q;
    len_d      = len_q;
    wait_d     = wait_q;
    held_d     = held_q;
    key_d      = key_q;
    ph_d       = ph_q;
    we         = 1'b0;
    case (state_q)
      S_IDLE: begin
        key_d = 7'd0;
        if (rec_btn && sel_ok) begin
          state_d         = S_REC;
          slot_d          = sel_idx;
          len_d[sel_idx]  = '0;
          delta_d         = '0;
          wr_ptr_d        = '0;
          prev_key_d      = key_in;
        end else if (play_btn && sel_ok && len_q[sel_idx] != '0) begin
          state_d  = S_FETCH;
          slot_d   = sel_idx;
          rd_ptr_d = '0;
          ph_d     = 1'b0;
        end
      end
      S_REC: begin
        if (rec_btn) begin
          state_d        = S_IDLE;
          len_d[slot_q]  = wr_ptr_q;
        end else if (key_in != prev_key_q) begin
          prev_key_d = key_in;
          if (wr_ptr_q != DEPTH_V) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            delta_d  = '0;
          end
        end
      end
      S_FETCH: begin
        if (play_btn) begin
          state_d = S_IDLE;
          key_d   = 7'd0;
        end else if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d    = 1'b0;
          wait_d  = rd_data_q[MW-1:7];
          held_d  = rd_data_q[6:0];
          state_d = S_WAIT;
        end
      end
      default: begin
        if (play_btn) begin
          state_d = S_IDLE;
          key_d   = 7'd0;
        end else if (rd_ptr_q == cur_len) begin
          // The final event has had its cycle on key_out; go silent
          state_d = S_IDLE;
          key_d   = 7'd0;
        end else if (wait_q == '0) begin
          key_d    = held_q;
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (rd_ptr_q + 1'b1 != cur_len) state_d = S_FETCH;
        end else if (tick) begin
          wait_d = wait_q - 1'b1;
        end
      end
    endcase
  end

  // State and counter registers, cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      delta_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      slot_q     <= 2'd0;
      prev_key_q <= 7'd0;
      for (int i = 0; i < 3; i++) len_q[i] <= '0;
      wait_q     <= '0;
      held_q     <= 7'd0;
      key_q      <= 7'd0;
      ph_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      delta_q    <= delta_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      slot_q     <= slot_d;
      prev_key_q <= prev_key_d;
      len_q      <= len_d;
      wait_q     <= wait_d;
      held_q     <= held_d;
      key_q      <= key_d;
      ph_q       <= ph_d;
    end
  end

  // Event memory: write port for recording, registered read for playback
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= {delta_q, key_in};
    rd_data_q <= mem[raddr];
  end

  // Status outputs derived from the current state
  always_comb begin
    event_count = '0;
    case (state_q)
      S_REC:   event_count = wr_ptr_q;
      S_FETCH,
      S_WAIT:  event_count = cur_len - rd_ptr_q;
      default: event_count = '0;
    endcase
  end

  assign key_out   = key_q;
  assign recording = (state_q == S_REC);
  assign playing   = (state_q == S_FETCH) || (state_q == S_WAIT);
  assign full      = (state_q == S_REC) && (wr_ptr_q == DEPTH_V);

endmodule
